// File: rtl/gbt_frameclk_pkg.sv
// Shared types and helpers for the GBT frame-clock strobe generator.
//   state_e     : alignment FSM states
//   phase_width : width of a frame-phase field for a given divide ratio
package gbt_frameclk_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  // A divide-by-1 frame still needs a 1-bit phase field.
  function automatic int unsigned phase_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/gbt_frameclk_phase_cnt.sv
// Frame phase counter: counts 0..DIV-1 on every clock and can be forced to
// restart a frame so that the realigning cycle itself is phase 0.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   realign   : next cnt = 1 % DIV instead of the normal increment
//   cnt       : current frame phase (registered)
//   wrap_c    : cnt is at the last phase of the frame (combinational)
module gbt_frameclk_phase_cnt #(
  parameter int unsigned DIV     = 3,
  parameter int unsigned PHASE_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               realign,
  output logic [PHASE_W-1:0] cnt,
  output logic               wrap_c
);

  localparam logic [PHASE_W-1:0] LAST_PHASE  = PHASE_W'(DIV - 1);
  localparam logic [PHASE_W-1:0] REALIGN_VAL = PHASE_W'(1 % DIV);

  logic [PHASE_W-1:0] cnt_nxt;

  assign wrap_c = (cnt == LAST_PHASE);

  // Realign wins over the wrap; for DIV==1 the wrap keeps cnt at 0.
  always_comb begin
    cnt_nxt = cnt + PHASE_W'(1);
    if (realign) begin
      cnt_nxt = REALIGN_VAL;
    end else if (wrap_c) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/gbt_frameclk_strobe_gen.sv
// Frame-clock strobe generator for the GBT TX path. Derives NUM_CLOCKS
// phase-programmable one-cycle frame strobes from the reference clock,
// aligns the frame to sync_i and qualifies lock over LOCK_COUNT good syncs.
// Ports:
//   refclk     : reference clock (only clock domain)
//   rst        : asynchronous reset, active-high
//   sync_i     : alignment pulse; the cycle it is high is phase 0
//   phase_i    : packed per-output phase fields, field k = [k*PHASE_W +: PHASE_W]
//   phase_ld   : load (saturated) phase_i into the phase registers
//   outclk_en  : per-output frame strobe, one cycle per frame
//   frame_cnt  : current frame phase 0..DIV-1
//   locked     : frame alignment qualified
//   sync_err   : one-cycle pulse on a misaligned sync or timeout while locked
module gbt_frameclk_strobe_gen
  import gbt_frameclk_pkg::*;
#(
  parameter int unsigned DIV           = 3,
  parameter int unsigned NUM_CLOCKS    = 2,
  parameter int unsigned PHASE_W       = phase_width(DIV),
  parameter int unsigned LOCK_COUNT    = 16,
  parameter int unsigned SYNC_TIMEOUT  = 256,
  parameter bit          GATE_UNLOCKED = 1'b0
) (
  input  logic                          refclk,
  input  logic                          rst,
  input  logic                          sync_i,
  input  logic [NUM_CLOCKS*PHASE_W-1:0] phase_i,
  input  logic                          phase_ld,
  output logic [NUM_CLOCKS-1:0]         outclk_en,
  output logic [PHASE_W-1:0]            frame_cnt,
  output logic                          locked,
  output logic                          sync_err
);

  localparam int unsigned        GOOD_W    = $clog2(LOCK_COUNT + 1);
  localparam int unsigned        TO_W      = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(DIV - 1);

  state_e                               state, state_nxt;
  logic [GOOD_W-1:0]                    good_cnt, good_nxt, good_inc;
  logic [TO_W-1:0]                      to_cnt, to_nxt;
  logic                                 sync_err_nxt;
  logic                                 locked_nxt;
  logic [PHASE_W-1:0]                   cnt;
  logic                                 wrap_c;
  logic                                 aligned_c, misaligned_c, realign_c;
  logic [NUM_CLOCKS-1:0][PHASE_W-1:0]   phase_r, phase_nxt;
  logic [NUM_CLOCKS-1:0]                hit_c, en_nxt;

  // Any sync while unlocked, or any off-phase sync, restarts the frame.
  assign aligned_c    = sync_i & (cnt == '0);
  assign misaligned_c = sync_i & (cnt != '0);
  assign realign_c    = misaligned_c | (sync_i & (state == UNLOCKED));
  assign good_inc     = good_cnt + GOOD_W'(1);
  assign frame_cnt    = cnt;

  gbt_frameclk_phase_cnt #(
    .DIV     (DIV),
    .PHASE_W (PHASE_W)
  ) u_phase_cnt (
    .clk     (refclk),
    .rst     (rst),
    .realign (realign_c),
    .cnt     (cnt),
    .wrap_c  (wrap_c)
  );

  // Alignment FSM: lock qualification and sync supervision.
  always_comb begin
    state_nxt    = state;
    good_nxt     = good_cnt;
    to_nxt       = '0;
    sync_err_nxt = 1'b0;
    unique case (state)
      UNLOCKED: begin
        if (sync_i) begin
          good_nxt  = GOOD_W'(1);
          state_nxt = (LOCK_COUNT <= 1) ? LOCKED : ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (aligned_c) begin
          good_nxt = good_inc;
          if (good_inc >= GOOD_W'(LOCK_COUNT)) begin
            state_nxt = LOCKED;
          end
        end else if (misaligned_c) begin
          good_nxt = GOOD_W'(1);
        end
      end
      LOCKED: begin
        to_nxt = to_cnt;
        if (misaligned_c) begin
          sync_err_nxt = 1'b1;
          good_nxt     = GOOD_W'(1);
          state_nxt    = ACQUIRE;
          to_nxt       = '0;
        end else if (aligned_c) begin
          // A sync landing on the timeout frame still counts as a sync.
          to_nxt = '0;
        end else if (wrap_c) begin
          if (to_cnt == TO_W'(SYNC_TIMEOUT - 1)) begin
            sync_err_nxt = 1'b1;
            state_nxt    = UNLOCKED;
            to_nxt       = '0;
          end else begin
            to_nxt = to_cnt + TO_W'(1);
          end
        end
      end
      default: begin
        state_nxt = UNLOCKED;
      end
    endcase
  end

  assign locked_nxt = (state_nxt == LOCKED);

  // Saturating phase load and strobe decode.
  always_comb begin
    phase_nxt = phase_r;
    hit_c     = '0;
    for (int k = 0; k < int'(NUM_CLOCKS); k++) begin
      if (phase_i[k*PHASE_W +: PHASE_W] > PHASE_MAX) begin
        phase_nxt[k] = PHASE_MAX;
      end else begin
        phase_nxt[k] = phase_i[k*PHASE_W +: PHASE_W];
      end
      hit_c[k] = (cnt == phase_r[k]);
    end
    // Gating with locked_nxt equals gating the output with the registered locked.
    en_nxt = GATE_UNLOCKED ? (hit_c & {NUM_CLOCKS{locked_nxt}}) : hit_c;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= UNLOCKED;
      good_cnt  <= '0;
      to_cnt    <= '0;
      locked    <= 1'b0;
      sync_err  <= 1'b0;
      phase_r   <= '0;
      outclk_en <= '0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_nxt;
      to_cnt    <= to_nxt;
      locked    <= locked_nxt;
      sync_err  <= sync_err_nxt;
      outclk_en <= en_nxt;
      if (phase_ld) begin
        phase_r <= phase_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gbt_frameclk_strobe_gen.sv
// Testbench for gbt_frameclk_strobe_gen: an ungated and a gated instance
// driven in parallel and compared cycle by cycle against a reference model.
module tb_gbt_frameclk_strobe_gen;

  localparam int DIV = 3;
  localparam int NC  = 2;
  localparam int PW  = 2;
  localparam int LC  = 16;
  localparam int TO  = 256;
  localparam int VW  = 2 * (NC + PW + 2);

  localparam int M_UNL = 0;
  localparam int M_ACQ = 1;
  localparam int M_LK  = 2;

  logic            refclk = 1'b0;
  logic            rst;
  logic            sync_i;
  logic            phase_ld;
  logic [NC*PW-1:0] phase_i;
  logic [NC-1:0]   outclk_en, outclk_en_g;
  logic [PW-1:0]   frame_cnt, frame_cnt_g;
  logic            locked, locked_g, sync_err, sync_err_g;

  int vectors;
  int miscompares;

  // Reference model state
  int            m_cnt, m_mode, m_good, m_frames;
  bit            m_locked, m_err;
  bit [NC-1:0]   m_en;
  int            m_ph [NC];

  always #5 refclk = ~refclk;

  gbt_frameclk_strobe_gen #(
    .DIV(DIV), .NUM_CLOCKS(NC), .LOCK_COUNT(LC), .SYNC_TIMEOUT(TO), .GATE_UNLOCKED(1'b0)
  ) u_dut (
    .refclk(refclk), .rst(rst), .sync_i(sync_i), .phase_i(phase_i), .phase_ld(phase_ld),
    .outclk_en(outclk_en), .frame_cnt(frame_cnt), .locked(locked), .sync_err(sync_err)
  );

  gbt_frameclk_strobe_gen #(
    .DIV(DIV), .NUM_CLOCKS(NC), .LOCK_COUNT(LC), .SYNC_TIMEOUT(TO), .GATE_UNLOCKED(1'b1)
  ) u_dut_g (
    .refclk(refclk), .rst(rst), .sync_i(sync_i), .phase_i(phase_i), .phase_ld(phase_ld),
    .outclk_en(outclk_en_g), .frame_cnt(frame_cnt_g), .locked(locked_g), .sync_err(sync_err_g)
  );

  function automatic logic [VW-1:0] dut_vec();
    return {outclk_en, frame_cnt, locked, sync_err, outclk_en_g, frame_cnt_g, locked_g, sync_err_g};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [NC-1:0] eg;
    eg = m_locked ? m_en : '0;
    return {m_en, PW'(m_cnt), m_locked, m_err, eg, PW'(m_cnt), m_locked, m_err};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_mode = M_UNL; m_good = 0; m_frames = 0;
    m_locked = 1'b0; m_err = 1'b0; m_en = '0;
    for (int k = 0; k < NC; k++) m_ph[k] = 0;
  endtask

  // Apply one cycle of stimulus, advance the model by its rules, then sample point.
  task automatic cycle(input bit s, input bit ld, input logic [NC*PW-1:0] ph);
    int          old_cnt, old_mode, f;
    bit          al, mis;
    sync_i = s; phase_ld = ld; phase_i = ph;
    old_cnt  = m_cnt;
    old_mode = m_mode;
    al  = s && (old_cnt == 0);
    mis = s && (old_cnt != 0);
    for (int k = 0; k < NC; k++) m_en[k] = (old_cnt == m_ph[k]);
    m_err = 1'b0;
    if (old_mode == M_UNL) begin
      if (s) begin m_good = 1; m_mode = (LC <= 1) ? M_LK : M_ACQ; end
    end else if (old_mode == M_ACQ) begin
      if (al) begin m_good++; if (m_good >= LC) m_mode = M_LK; end
      else if (mis) m_good = 1;
    end else begin
      if (mis) begin m_err = 1'b1; m_good = 1; m_mode = M_ACQ; end
      else if (al) m_frames = 0;
      else if (old_cnt == DIV - 1) begin
        m_frames++;
        if (m_frames == TO) begin m_err = 1'b1; m_mode = M_UNL; end
      end
    end
    if (m_mode != M_LK) m_frames = 0;
    m_cnt = (s && (old_cnt != 0 || old_mode == M_UNL)) ? (1 % DIV) : ((old_cnt + 1) % DIV);
    if (ld) begin
      for (int k = 0; k < NC; k++) begin
        f = int'(ph[k*PW +: PW]);
        m_ph[k] = (f > DIV - 1) ? DIV - 1 : f;
      end
    end
    m_locked = (m_mode == M_LK);
    @(posedge refclk);
    #1;
    sync_i = 1'b0; phase_ld = 1'b0;
  endtask

  // Idle until the model frame phase reaches target (stimulus positioning only).
  task automatic advance_to(input int target);
    for (int i = 0; i < DIV && m_cnt != target; i++) cycle(1'b0, 1'b0, phase_i);
  endtask

  task automatic test_reset();
    rst = 1'b1; sync_i = 1'b0; phase_ld = 1'b0; phase_i = '0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge refclk); #1;
      vectors++;
      if (dut_vec() !== '0) begin
        miscompares++;
        $display("FAIL reset_hold cyc %0d: got %b want 0", i, dut_vec());
      end
    end
    rst = 1'b0;
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_release: got %b want %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b0, '0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL free_run cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      vectors++;
      if (outclk_en[0] !== (i % 3 == 0) || frame_cnt !== PW'((i + 1) % 3) || locked !== 1'b0) begin
        miscompares++;
        $display("FAIL free_run_pattern cyc %0d: got en=%b cnt=%0d lk=%b want en=%b cnt=%0d lk=0",
                 i, outclk_en[0], frame_cnt, locked, (i % 3 == 0), (i + 1) % 3);
      end
    end
  endtask

  task automatic test_acquire();
    advance_to(2);
    for (int n = 1; n <= LC; n++) begin
      if (n > 1) advance_to(0);
      cycle(1'b1, 1'b0, '0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL acquire sync %0d: got %b want %b", n, dut_vec(), exp_vec());
      end
      vectors++;
      if (locked !== (n == LC) || sync_err !== 1'b0) begin
        miscompares++;
        $display("FAIL acquire_lock sync %0d: got lk=%b err=%b want lk=%b err=0",
                 n, locked, sync_err, (n == LC));
      end
    end
  endtask

  task automatic test_phase();
    logic [NC*PW-1:0] ph;
    int pre;
    ph = {2'd1, 2'd2};
    cycle(1'b0, 1'b1, ph);
    for (int i = 0; i < 6; i++) begin
      pre = m_cnt;
      cycle(1'b0, 1'b0, ph);
      vectors++;
      if (dut_vec() !== exp_vec() || outclk_en[0] !== (pre == 2) || outclk_en[1] !== (pre == 1)) begin
        miscompares++;
        $display("FAIL phase_21 cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    ph = {2'd3, 2'd3};
    cycle(1'b0, 1'b1, ph);
    for (int i = 0; i < 6; i++) begin
      pre = m_cnt;
      cycle(1'b0, 1'b0, ph);
      vectors++;
      if (dut_vec() !== exp_vec() || outclk_en !== ((pre == 2) ? 2'b11 : 2'b00)) begin
        miscompares++;
        $display("FAIL phase_sat cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_misalign();
    advance_to(1);
    cycle(1'b1, 1'b0, phase_i);
    vectors++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || frame_cnt !== PW'(1) || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL misalign_err: got err=%b lk=%b cnt=%0d want err=1 lk=0 cnt=1",
               sync_err, locked, frame_cnt);
    end
    cycle(1'b0, 1'b0, phase_i);
    vectors++;
    if (sync_err !== 1'b0 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL misalign_pulse: got err=%b want 0", sync_err);
    end
    for (int j = 1; j <= LC - 1; j++) begin
      advance_to(0);
      cycle(1'b1, 1'b0, phase_i);
      vectors++;
      if (locked !== (j == LC - 1) || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL relock sync %0d: got lk=%b want lk=%b", j, locked, (j == LC - 1));
      end
    end
  endtask

  task automatic test_timeout();
    int err_at;
    err_at = -1;
    advance_to(0);
    cycle(1'b1, 1'b0, phase_i);
    for (int i = 1; i <= DIV * TO + DIV && err_at < 0; i++) begin
      cycle(1'b0, 1'b0, phase_i);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL timeout_run cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (sync_err === 1'b1) err_at = i;
    end
    vectors++;
    if (err_at != DIV * TO - 1) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d want %0d", err_at, DIV * TO - 1);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, phase_i);
      vectors++;
      if (locked !== 1'b0 || outclk_en_g !== '0 || sync_err !== 1'b0 || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL timeout_after cyc %0d: got lk=%b en_g=%b err=%b want 0 0 0",
                 i, locked, outclk_en_g, sync_err);
      end
    end
  endtask

  task automatic test_rst_midframe();
    cycle(1'b1, 1'b0, phase_i);
    for (int j = 1; j < LC; j++) begin
      advance_to(0);
      cycle(1'b1, 1'b0, phase_i);
    end
    vectors++;
    if (locked !== 1'b1 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL prereset_lock: got lk=%b want 1", locked);
    end
    advance_to(1);
    rst = 1'b1;
    #1;
    vectors++;
    if (dut_vec() !== '0) begin
      miscompares++;
      $display("FAIL async_rst: got %b want 0", dut_vec());
    end
    model_reset();
    @(posedge refclk); @(posedge refclk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, phase_i);
      vectors++;
      if (dut_vec() !== exp_vec() || outclk_en[0] !== (i % 3 == 0)) begin
        miscompares++;
        $display("FAIL post_reset cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit s, ld;
    logic [NC*PW-1:0] ph;
    for (int i = 0; i < 3000; i++) begin
      s  = (m_cnt == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 40) == 0);
      ld = ($urandom_range(0, 63) == 0);
      ph = NC*PW'($urandom);
      cycle(s, ld, ph);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_free_run();
    test_acquire();
    test_phase();
    test_misalign();
    test_timeout();
    test_rst_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
